// File: rtl/trace_sequencer_pkg.sv
// trace_sequencer_pkg: shared op codes and sequencer state type
package trace_sequencer_pkg;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: trace entry FIFO with wrap-bit pointers and async reset
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 57
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];
  // pointer advance; a push while full is refused even if a pop happens the same cycle
  always_comb begin
    wr_d = (push && !full) ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = (pop && !empty) ? rd_q + (AW+1)'(1) : rd_q;
  end
  // pointer and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: buffers trace entries and issues validated requests to the cache engine
module trace_sequencer
  import trace_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 48,
  parameter int OP_W   = 8,
  parameter int CNT_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [OP_W-1:0]   load_op,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_last,
  input  logic              start,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [OP_W-1:0]   cache_op,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  reads_issued,
  output logic [CNT_W-1:0]  writes_issued,
  output logic [CNT_W-1:0]  bad_ops
);
  localparam int EW = OP_W + ADDR_W + 1;
  logic              f_push, f_pop, f_full, f_empty;
  logic [EW-1:0]     f_rdata;
  logic [OP_W-1:0]   head_op;
  logic [ADDR_W-1:0] head_addr;
  logic              head_last, head_legal, accept, stage_free;
  seq_state_t        state_q, state_d;
  logic              vld_q, vld_d, last_q, last_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, bad_q, bad_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign f_push     = load_valid && !f_full;
  assign load_ready = !f_full;
  assign {head_op, head_addr, head_last} = f_rdata;
  assign head_legal = (head_op == OP_W'(OP_READ)) || (head_op == OP_W'(OP_WRITE));
  assign accept     = vld_q && req_ready;
  // the output stage can take a new head when idle or being accepted, unless the accepted one ends the trace
  assign stage_free = !vld_q || (req_ready && !last_q);

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .pop   (f_pop),
    .wdata ({load_op, load_addr, load_last}),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  // retire accepted requests, pop/validate the next head, and sequence IDLE/RUN/DONE
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    op_d    = op_q;
    addr_d  = addr_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    f_pop   = 1'b0;
    if (accept) begin
      vld_d   = 1'b0;
      rd_d    = (op_q == OP_W'(OP_READ))  ? sat_inc(rd_q) : rd_q;
      wr_d    = (op_q == OP_W'(OP_WRITE)) ? sat_inc(wr_q) : wr_q;
      state_d = last_q ? DONE : state_q;
    end
    if (state_q == RUN && stage_free && !f_empty) begin
      f_pop   = 1'b1;
      vld_d   = head_legal;
      op_d    = head_legal ? head_op : op_q;
      addr_d  = head_legal ? head_addr : addr_q;
      last_d  = head_legal ? head_last : last_q;
      bad_d   = head_legal ? bad_q : sat_inc(bad_q);
      state_d = (!head_legal && head_last) ? DONE : state_d;
    end
    if (state_q != RUN && start) state_d = RUN;
  end

  // state, output stage and statistic registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
    end
  end

  assign req_valid     = vld_q;
  assign cache_op      = op_q;
  assign cache_addr    = addr_q;
  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign reads_issued  = rd_q;
  assign writes_issued = wr_q;
  assign bad_ops       = bad_q;
endmodule

// File: tb/tb_trace_sequencer.sv
// tb_trace_sequencer: randomized trace bench against a transaction-level queue model
module tb_trace_sequencer;
  localparam int DEPTH = 16, ADDR_W = 48, OP_W = 8, CNT_W = 18, SCW = 4;
  localparam logic [7:0] R = 8'h52, W = 8'h57;

  logic clk = 1'b0;
  logic reset, load_valid, load_last, start, req_ready;
  logic [OP_W-1:0] load_op;
  logic [ADDR_W-1:0] load_addr;
  logic load_ready, req_valid, busy, done;
  logic [OP_W-1:0] cache_op;
  logic [ADDR_W-1:0] cache_addr;
  logic [CNT_W-1:0] reads_issued, writes_issued, bad_ops;
  logic s_load_ready, s_req_valid, s_busy, s_done;
  logic [OP_W-1:0] s_cache_op;
  logic [ADDR_W-1:0] s_cache_addr;
  logic [SCW-1:0] s_reads, s_writes, s_bad;

  always #5 clk = ~clk;

  trace_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_op(load_op), .load_addr(load_addr), .load_last(load_last), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .cache_op(cache_op), .cache_addr(cache_addr),
    .busy(busy), .done(done), .reads_issued(reads_issued), .writes_issued(writes_issued),
    .bad_ops(bad_ops)
  );

  trace_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(SCW)) dut_s (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_op(load_op), .load_addr(load_addr), .load_last(load_last), .start(start),
    .req_valid(s_req_valid), .req_ready(req_ready), .cache_op(s_cache_op), .cache_addr(s_cache_addr),
    .busy(s_busy), .done(s_done), .reads_issued(s_reads), .writes_issued(s_writes),
    .bad_ops(s_bad)
  );

  typedef struct packed {logic [7:0] op; logic [47:0] addr; logic last;} ent_t;
  ent_t pend[$];
  ent_t mq[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  int acc_cyc[$];
  longint m_rd = 0, m_wr = 0, m_bad = 0;
  bit last_ret = 0, rr_rand = 0;
  logic rr_fixed = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=event expected=none", tag);
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit legal(input logic [7:0] op);
    return op == R || op == W;
  endfunction

  task automatic model_accept();
    ent_t e;
    while (mq.size() > 0 && !legal(mq[0].op)) begin
      m_bad++;
      void'(mq.pop_front());
    end
    if (mq.size() == 0) begin
      fail("unexpected_accept");
      return;
    end
    e = mq.pop_front();
    chk("req_op", cache_op, e.op);
    chk("req_addr", cache_addr, e.addr);
    chk("s_req_addr", s_cache_addr, e.addr);
    if (e.op == R) m_rd++; else m_wr++;
    last_ret = e.last;
    acc_cnt++;
    acc_cyc.push_back(cyc);
  endtask

  task automatic model_finish();
    ent_t e;
    if (!last_ret) begin
      while (mq.size() > 0) begin
        e = mq.pop_front();
        if (legal(e.op)) fail("request_missing");
        else m_bad++;
        if (e.last) break;
      end
    end
    last_ret = 0;
  endtask

  task automatic drive_load();
    load_valid = pend.size() > 0;
    if (pend.size() > 0) {load_op, load_addr, load_last} = pend[0];
  endtask

  task automatic tick();
    if (load_valid && load_ready) mq.push_back(pend.pop_front());
    if (req_valid && req_ready) model_accept();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    drive_load();
    req_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  endtask

  task automatic add(input logic [7:0] op, input logic [47:0] addr, input logic last);
    pend.push_back({op, addr, last});
    drive_load();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_reads"}, reads_issued, sat(m_rd, CNT_W));
    chk({tag, "_writes"}, writes_issued, sat(m_wr, CNT_W));
    chk({tag, "_bad"}, bad_ops, sat(m_bad, CNT_W));
    chk({tag, "_s_reads"}, s_reads, sat(m_rd, SCW));
    chk({tag, "_s_writes"}, s_writes, sat(m_wr, SCW));
    chk({tag, "_s_bad"}, s_bad, sat(m_bad, SCW));
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_s_done"}, s_done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_valid"}, req_valid, 0);
    model_finish();
    check_counts(tag);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req_valid"}, req_valid, 1);
  endtask

  task automatic clear_model();
    pend.delete();
    mq.delete();
    m_rd = 0;
    m_wr = 0;
    m_bad = 0;
    last_ret = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n;
    logic [7:0] op;
    reset = 1'b1; load_valid = 1'b0; load_op = '0; load_addr = '0; load_last = 1'b0;
    start = 1'b0; req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_cache_op", cache_op, 0);
    chk("rst_cache_addr", cache_addr, 0);
    check_counts("rst");
    reset = 1'b0;
    tick();

    rr_fixed = 1'b1; req_ready = 1'b1;
    add(R, 48'h0000_1000_0040, 0);
    add(W, 48'h0000_2000_0080, 1);
    repeat (3) tick();
    a0 = acc_cnt;
    kick();
    chk("basic_busy", busy, 1);
    wait_done("basic", 20);
    chk("basic_accepts", acc_cnt - a0, 2);
    chk("basic_back_to_back", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 1);

    rr_fixed = 1'b0; req_ready = 1'b0;
    add(R, 48'h40, 0);
    add(W, 48'h80, 1);
    repeat (3) tick();
    kick();
    wait_req("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_op", cache_op, R);
      chk("bp_addr", cache_addr, 48'h40);
      chk("bp_reads", reads_issued, sat(m_rd, CNT_W));
      tick();
    end
    rr_fixed = 1'b1; req_ready = 1'b1;
    wait_done("bp", 20);

    a0 = acc_cnt;
    add(R, 48'h1234, 0);
    add(8'h58, 48'h5678, 0);
    add(W, 48'h9abc, 1);
    repeat (4) tick();
    kick();
    wait_done("ill", 20);
    chk("ill_accepts", acc_cnt - a0, 2);

    rr_fixed = 1'b0; req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      add(($urandom_range(0, 1) != 0) ? R : W, 48'({$urandom(), $urandom()}), i == DEPTH - 1);
    add(R, 48'h0bad_0000_0017, 0);
    repeat (DEPTH + 3) tick();
    chk("full_load_ready", load_ready, 0);
    chk("full_s_load_ready", s_load_ready, 0);
    chk("full_occupancy", mq.size(), DEPTH);
    kick();
    chk("full_still_full", load_ready, 0);
    tick();
    chk("full_after_pop", load_ready, 1);
    rr_fixed = 1'b1; req_ready = 1'b1;
    wait_done("full", 100);
    chk("full_queued_after_last", mq.size(), 1);

    rr_fixed = 1'b0; req_ready = 1'b0;
    kick();
    wait_req("mid");
    reset = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("mid_req_valid", req_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_load_ready", load_ready, 1);
    clear_model();
    check_counts("mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    rr_rand = 1;
    for (int i = 0; i < 20; i++) add(R, 48'({$urandom(), $urandom()}), i == 19);
    tick();
    kick();
    wait_done("sat", 400);
    chk("sat_s_reads", s_reads, 15);
    chk("sat_reads", reads_issued, 20);

    for (int t = 0; t < 6; t++) begin
      rr_rand = $urandom_range(0, 1) != 0;
      rr_fixed = 1'b1;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: op = R;
          4, 5, 6, 7: op = W;
          default: op = 8'($urandom());
        endcase
        add(op, 48'({$urandom(), $urandom()}), i == n - 1);
      end
      repeat ($urandom_range(0, 5)) tick();
      kick();
      wait_done("rnd", 2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
